// File: rtl/exc_ctrl.sv
// exc_ctrl: edge-detected IRQ queue and exception FSM arbitrating IRQs against invalid-opcode traps
module exc_ctrl #(
  parameter int N = 64,
  parameter int NIRQ = 4,
  parameter int ESW = 4,
  parameter logic [N-1:0] VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] ExtIRQ,
  input  logic [NIRQ-1:0] IrqMask,
  input  logic            NotAnInstr,
  input  logic            ERet,
  input  logic [N-1:0]    imem_addr_D,
  input  logic [N-1:0]    pc_resume,
  output logic            Exc,
  output logic [N-1:0]    Exc_vector,
  output logic [NIRQ-1:0] ExtIAck,
  output logic [ESW-1:0]  EStatus,
  output logic [ESW-1:0]  ESR,
  output logic [N-1:0]    ELR,
  output logic            InHandler,
  output logic            Fatal
);
  localparam int IW = NIRQ > 1 ? $clog2(NIRQ) : 1;
  typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RETURN} state_t;
  state_t state, state_n;
  logic [NIRQ-1:0] irq_prev, pend, pend_n, avail;
  logic [IW-1:0] idx, idx_n, sel;
  logic irq, irq_n, fatal_n;
  logic [ESW-1:0] esr_n, irq_code;
  logic [N-1:0] elr_n;
  assign avail = pend & ~IrqMask;
  assign irq_code = ESW'(1 << (ESW-1)) | ESW'(sel);
  assign Exc = state == TAKE;
  assign InHandler = state == TAKE || state == HANDLER;
  assign EStatus = InHandler ? ESR : '0;
  assign ExtIAck = (state == TAKE && irq) ? NIRQ'(1) << idx : '0;
  assign Exc_vector = VECTOR;
  // a fresh edge in the acknowledge cycle re-arms the channel
  assign pend_n = (pend & ~ExtIAck) | (ExtIRQ & ~irq_prev);
  always_comb begin
    sel = '0;
    for (int i = NIRQ-1; i >= 0; i--)
      if (avail[i]) sel = IW'(i);
  end
  always_comb begin
    state_n = state;
    esr_n = ESR;
    elr_n = ELR;
    idx_n = idx;
    irq_n = irq;
    fatal_n = Fatal;
    case (state)
      IDLE:
        if (NotAnInstr) begin
          state_n = TAKE;
          esr_n = ESW'(2);
          elr_n = imem_addr_D;
          irq_n = 1'b0;
        end else if (|avail) begin
          state_n = TAKE;
          esr_n = irq_code;
          elr_n = pc_resume;
          idx_n = sel;
          irq_n = 1'b1;
        end
      TAKE: state_n = HANDLER;
      HANDLER:
        if (ERet) state_n = RETURN;
        else if (NotAnInstr) begin
          fatal_n = 1'b1;
          esr_n = '1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      irq_prev <= '0;
      pend <= '0;
      idx <= '0;
      irq <= 1'b0;
      ESR <= '0;
      ELR <= '0;
      Fatal <= 1'b0;
    end else begin
      state <= state_n;
      irq_prev <= ExtIRQ;
      pend <= pend_n;
      idx <= idx_n;
      irq <= irq_n;
      ESR <= esr_n;
      ELR <= elr_n;
      Fatal <= fatal_n;
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenario tasks with hand-computed expectations for exc_ctrl
module tb_exc_ctrl;
  logic clk = 0, reset = 0;
  logic [3:0] ExtIRQ = 0, IrqMask = 0;
  logic NotAnInstr = 0, ERet = 0;
  logic [63:0] imem_addr_D = 0, pc_resume = 0;
  logic Exc, InHandler, Fatal;
  logic [63:0] Exc_vector, ELR;
  logic [3:0] ExtIAck, EStatus, ESR;
  int chk = 0, err = 0;

  exc_ctrl dut (.clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .IrqMask(IrqMask),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .imem_addr_D(imem_addr_D), .pc_resume(pc_resume),
    .Exc(Exc), .Exc_vector(Exc_vector), .ExtIAck(ExtIAck), .EStatus(EStatus), .ESR(ESR),
    .ELR(ELR), .InHandler(InHandler), .Fatal(Fatal));

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(3);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk++; if ({Exc, InHandler, Fatal, ExtIAck, EStatus, ESR} !== 15'd0 || ELR !== 64'd0) begin
        err++; $display("FAIL reset_idle cyc %0d got exc=%b inh=%b fat=%b ack=%b est=%b esr=%b elr=%h exp all 0", i, Exc, InHandler, Fatal, ExtIAck, EStatus, ESR, ELR);
      end
    end
    chk++; if (Exc_vector !== 64'hD8) begin err++; $display("FAIL exc_vector got %h exp d8", Exc_vector); end
    ERet = 1; tick(); ERet = 0; tick();
    chk++; if (Exc !== 0 || InHandler !== 0) begin err++; $display("FAIL eret_idle got exc=%b inh=%b exp 0 0", Exc, InHandler); end
  endtask

  task automatic test_irq_pair;
    ExtIRQ = 4'b0110; pc_resume = 64'h40;
    tick();
    chk++; if (Exc !== 0) begin err++; $display("FAIL irq_lat1 got exc=%b exp 0", Exc); end
    tick();
    chk++; if (Exc !== 1 || ExtIAck !== 4'b0010 || EStatus !== 4'b1001 || ELR !== 64'h40 || InHandler !== 1) begin
      err++; $display("FAIL irq1_take got exc=%b ack=%b est=%b elr=%h inh=%b exp 1 0010 1001 40 1", Exc, ExtIAck, EStatus, ELR, InHandler);
    end
    tick();
    chk++; if (Exc !== 0 || ExtIAck !== 0 || EStatus !== 4'b1001 || InHandler !== 1) begin
      err++; $display("FAIL irq1_handler got exc=%b ack=%b est=%b inh=%b exp 0 0000 1001 1", Exc, ExtIAck, EStatus, InHandler);
    end
    ERet = 1; tick(); ERet = 0;
    chk++; if (InHandler !== 0 || EStatus !== 0 || Exc !== 0 || ESR !== 4'b1001) begin
      err++; $display("FAIL return_state got inh=%b est=%b exc=%b esr=%b exp 0 0000 0 1001", InHandler, EStatus, Exc, ESR);
    end
    tick();
    chk++; if (Exc !== 0) begin err++; $display("FAIL idle_after_ret got exc=%b exp 0", Exc); end
    tick();
    chk++; if (Exc !== 1 || ExtIAck !== 4'b0100 || EStatus !== 4'b1010 || ESR !== 4'b1010) begin
      err++; $display("FAIL irq2_take got exc=%b ack=%b est=%b esr=%b exp 1 0100 1010 1010", Exc, ExtIAck, EStatus, ESR);
    end
    tick(); ERet = 1; tick(); ERet = 0; tick();
    ExtIRQ = 0;
    chk++; if (ESR !== 4'b1010 || InHandler !== 0) begin err++; $display("FAIL esr_persist got esr=%b inh=%b exp 1010 0", ESR, InHandler); end
    tick();
    chk++; if (Exc !== 0) begin err++; $display("FAIL no_spurious got exc=%b exp 0", Exc); end
  endtask

  task automatic test_nai_vs_irq;
    NotAnInstr = 1; imem_addr_D = 64'h1C; ExtIRQ = 4'b0001;
    tick();
    NotAnInstr = 0;
    chk++; if (Exc !== 1 || ESR !== 4'b0010 || EStatus !== 4'b0010 || ELR !== 64'h1C || ExtIAck !== 0) begin
      err++; $display("FAIL nai_take got exc=%b esr=%b est=%b elr=%h ack=%b exp 1 0010 0010 1c 0000", Exc, ESR, EStatus, ELR, ExtIAck);
    end
    ExtIRQ = 0;
    tick(); ERet = 1; tick(); ERet = 0; tick(); tick();
    chk++; if (Exc !== 1 || ExtIAck !== 4'b0001 || EStatus !== 4'b1000 || ELR !== 64'h40) begin
      err++; $display("FAIL irq0_after_nai got exc=%b ack=%b est=%b elr=%h exp 1 0001 1000 40", Exc, ExtIAck, EStatus, ELR);
    end
    tick();
  endtask

  task automatic test_fatal;
    NotAnInstr = 1; imem_addr_D = 64'h99; tick(); NotAnInstr = 0;
    chk++; if (Fatal !== 1 || ESR !== 4'b1111 || ELR !== 64'h40 || InHandler !== 1 || Exc !== 0) begin
      err++; $display("FAIL double_fault got fat=%b esr=%b elr=%h inh=%b exc=%b exp 1 1111 40 1 0", Fatal, ESR, ELR, InHandler, Exc);
    end
    ERet = 1; tick(); ERet = 0;
    chk++; if (Fatal !== 1 || InHandler !== 0) begin err++; $display("FAIL fatal_return got fat=%b inh=%b exp 1 0", Fatal, InHandler); end
    tick(2);
    chk++; if (Fatal !== 1 || Exc !== 0) begin err++; $display("FAIL fatal_sticky got fat=%b exc=%b exp 1 0", Fatal, Exc); end
  endtask

  task automatic test_mask;
    IrqMask = 4'b0001; ExtIRQ = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk++; if (Exc !== 0) begin err++; $display("FAIL masked cyc %0d got exc=%b exp 0", i, Exc); end
    end
    IrqMask = 0;
    tick();
    chk++; if (Exc !== 1 || ExtIAck !== 4'b0001 || EStatus !== 4'b1000) begin
      err++; $display("FAIL unmask_take got exc=%b ack=%b est=%b exp 1 0001 1000", Exc, ExtIAck, EStatus);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    chk++; if (InHandler !== 1) begin err++; $display("FAIL pre_reset_handler got inh=%b exp 1", InHandler); end
    ExtIRQ = 4'b1000; reset = 0; #1;
    chk++; if ({Exc, InHandler, Fatal, ExtIAck, EStatus, ESR} !== 15'd0 || ELR !== 64'd0) begin
      err++; $display("FAIL async_reset got exc=%b inh=%b fat=%b ack=%b est=%b esr=%b elr=%h exp all 0", Exc, InHandler, Fatal, ExtIAck, EStatus, ESR, ELR);
    end
    tick(2);
    reset = 1;
    tick();
    chk++; if (Exc !== 0) begin err++; $display("FAIL post_reset_edge got exc=%b exp 0", Exc); end
    tick();
    chk++; if (Exc !== 1 || ExtIAck !== 4'b1000 || EStatus !== 4'b1011 || ELR !== 64'h40) begin
      err++; $display("FAIL irq3_after_reset got exc=%b ack=%b est=%b elr=%h exp 1 1000 1011 40", Exc, ExtIAck, EStatus, ELR);
    end
  endtask

  initial begin
    test_reset;
    test_irq_pair;
    test_nai_vs_irq;
    test_fatal;
    test_mask;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Parametrised exception and interrupt controller for the LEGv8 pipeline. It sits beside the main decoder and takes over the exception role that the decoder previously flagged combinationally. It edge-detects and queues `NIRQ` external interrupt lines, and arbitrates them against the decoder's invalid-opcode flag. When an exception is taken it latches the cause and return address, emits a one-cycle redirect, masks further entry while the handler runs, and releases on `ERet`.

## Interface

Parameters:
- `N` — 64 — PC / address width.
- `NIRQ` — 4 — number of external interrupt channels; must satisfy `NIRQ <= 2**(ESW-1)`.
- `ESW` — 4 — exception-status code width.
- `VECTOR` — 64'h0000_0000_0000_00D8 — handler entry address.

Ports (clock and reset first):
- `clk` — in — 1 — system clock; all state updates on the rising edge.
- `reset` — in — 1 — asynchronous, active-low reset.
- `ExtIRQ` — in — NIRQ — external interrupt requests; level signals, rising edge = request.
- `IrqMask` — in — NIRQ — 1 = channel may not be taken; its pending bit is kept.
- `NotAnInstr` — in — 1 — invalid opcode in the decode stage, from the main decoder.
- `ERet` — in — 1 — exception return is committing.
- `imem_addr_D` — in — N — PC of the instruction currently in decode.
- `pc_resume` — in — N — address at which to resume after an interrupt.
- `Exc` — out — 1 — one-cycle pulse: flush the pipeline and fetch from `Exc_vector`.
- `Exc_vector` — out — N — constant `VECTOR`.
- `ExtIAck` — out — NIRQ — one-hot acknowledge, pulsed together with `Exc`.
- `EStatus` — out — ESW — cause code while in TAKE or HANDLER; 0 otherwise.
- `ESR` — out — ESW — cause of the last exception taken; persists after return.
- `ELR` — out — N — return address; `ERet` targets this.
- `InHandler` — out — 1 — high in TAKE and HANDLER.
- `Fatal` — out — 1 — sticky double-fault flag; cleared only by reset.

## Operation

- Cause codes:
  - 0 = none.
  - `ESW'b0010` = invalid opcode.
  - IRQ channel k = `(1<<(ESW-1)) + k`.
  - all-ones = double fault.
- Edge detect: `irq_prev` register per channel. `pend[k]` is set at the posedge where `ExtIRQ[k]=1 && irq_prev[k]=0`. It is cleared at the posedge that leaves TAKE with `ExtIAck[k]=1`. If a new edge arrives in that same cycle, set wins.
- FSM states: IDLE, TAKE, HANDLER, RETURN.
- IDLE:
  - If `NotAnInstr`: go to TAKE, `ESR<=0010`, `ELR<=imem_addr_D`.
  - Otherwise, if `pend & ~IrqMask` is nonzero: select the lowest index k, go to TAKE, `ESR<=IRQ code k`, `ELR<=pc_resume`, and record k.
  - `NotAnInstr` always beats IRQs.
  - `ERet` in IDLE is ignored; no state change.
- TAKE (exactly one cycle):
  - `Exc=1`; `ExtIAck[k]=1` if the cause is an IRQ, all zero otherwise.
  - Next state: HANDLER.
- HANDLER:
  - IRQ edges continue to set `pend`, but no IRQ is taken.
  - `NotAnInstr` sets `Fatal<=1` and `ESR<=all-ones`; `ELR` is unchanged and the state stays HANDLER.
  - `ERet` moves to RETURN.
  - If `ERet` and `NotAnInstr` occur together, `ERet` wins and no fault is recorded.
- RETURN (one cycle): `EStatus=0`, `InHandler=0`, `Exc=0`, next state IDLE. Pending IRQs are evaluated in IDLE, so back-to-back handlers are allowed.
- `IrqMask` changes take effect on the next IDLE decision. Masked channels keep their pending bit.

## Timing

- Reset values:
  - State IDLE; `pend`, `irq_prev`, and the recorded index all 0.
  - `Exc=0`, `ExtIAck=0`, `EStatus=0`, `ESR=0`, `ELR=0`, `InHandler=0`, `Fatal=0`.
- Reset asserted mid-handler aborts immediately to the reset state. Because `irq_prev` resets to 0, a line held high through reset release registers as an edge at the first clock.
- IRQ latency:
  - rising edge sampled at posedge P0 → `pend` set;
  - P1 → TAKE;
  - `Exc` and `ExtIAck` are high for the cycle after P1.
  - The earliest `Exc` is therefore 2 cycles after the sampled edge.
- `NotAnInstr` latency: sampled at P0 → TAKE; `Exc` is high for the cycle after P0.
- `ERet` sampled at posedge Pe in HANDLER → RETURN after Pe → IDLE after Pe+1. The earliest next `Exc` is in the cycle after Pe+2.
- `Exc`, `ExtIAck`, `EStatus`, and `InHandler` are decoded from registered state only; there is no combinational path from inputs.

## Test plan

- Reset release, no stimulus, 10 cycles → all outputs 0; state stays IDLE.
- `ExtIRQ=4'b0110` rising together, `pc_resume=64'h40`:
  - → channel 1 is taken first: `Exc` 2 cycles later, `ExtIAck=0010`, `EStatus=4'b1001`, `ELR=64'h40`;
  - `ERet` → after RETURN, channel 2 is taken with `EStatus=4'b1010`.
- `NotAnInstr=1` with `imem_addr_D=64'h1C` in the same cycle as a `pend[0]` edge → `Exc` after 1 cycle, `ESR=0010`, `ELR=64'h1C`, `ExtIAck=0`; IRQ0 is taken after `ERet`.
- In HANDLER, `NotAnInstr=1` → `Fatal=1`, `ESR=4'b1111`; `Fatal` stays 1 through `ERet` until reset.
- `IrqMask=4'b0001`, edge on channel 0 → no `Exc`; clear the mask → `Exc` on channel 0 within 2 cycles.
- Assert reset in HANDLER while `ExtIRQ[3]` is held high → all outputs clear. After release, channel 3 is taken, `Exc` 2 cycles after the first clock edge.
